// File: rtl/timer_pkg.sv
// Shared types and constants for the byte-wide timer bus controller.
package timer_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_e;

  localparam logic [1:0] REG_MTIME = 2'b00;
  localparam logic [1:0] REG_CMP = 2'b01;
  localparam logic [1:0] DEF_CMP_SEL = REG_CMP;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/timer_bus_ctrl_arb.sv
// Two-way round-robin arbiter: on a tie the index that did not win last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic [1:0] grant
);
  always_comb begin
    grant = '0;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end
endmodule

// File: rtl/timer_bus_ctrl.sv
// Arbitrates two word requesters and sequences each word as four
// little-endian byte cycles on the timer bus.
module timer_bus_ctrl
  import timer_pkg::*;
#(
  parameter int         ADDR_WIDTH = 17,
  parameter logic [1:0] CMP_SEL    = DEF_CMP_SEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]             req_wdata,
  output logic                    resp_valid,
  output logic                    resp_id,
  output logic [31:0]             resp_rdata,
  output logic                    tmr_en,
  output logic                    tmr_r_nw,
  output logic [ADDR_WIDTH-1:0]   tmr_addr,
  output logic [7:0]              tmr_dout,
  input  logic [7:0]              tmr_din,
  input  logic                    tmr_irq_in,
  output logic                    irq_out
);
  localparam int HW = ADDR_WIDTH - 2;
  localparam logic [1:0] LAST_K = 2'(BYTES_PER_WORD - 1);

  state_e          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic            we_q, we_d;
  logic [HW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            id_q, id_d;
  logic            rr_last_q, rr_last_d;
  logic            mask_q, mask_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irq_q, irq_d;

  logic [1:0]            grant;
  logic                  gid;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic [1:0]            cap_idx;

  rr_arb2 u_arb (
    .valid   (req_valid),
    .rr_last (rr_last_q),
    .grant   (grant)
  );

  assign gid       = grant[1];
  assign sel_we    = gid ? req_we[1] : req_we[0];
  assign sel_addr  = gid ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                         : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = gid ? req_wdata[63:32] : req_wdata[31:0];
  assign cap_idx   = k_q - 2'd1;
  assign irq_out   = irq_q;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    id_d       = id_q;
    rr_last_d  = rr_last_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    resp_id    = 1'b0;
    resp_rdata = '0;
    tmr_en     = 1'b0;
    tmr_r_nw   = 1'b0;
    tmr_addr   = '0;
    tmr_dout   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant != 2'b00) begin
          we_d      = sel_we;
          addr_d    = sel_addr[ADDR_WIDTH-1:2];
          wdata_d   = sel_wdata;
          id_d      = gid;
          rr_last_d = gid;
          k_d       = 2'd0;
          rdata_d   = '0;
          mask_d    = sel_we && (sel_addr[3:2] == CMP_SEL);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tmr_en   = 1'b1;
        tmr_r_nw = ~we_q;
        tmr_addr = {addr_q, k_q};
        tmr_dout = wdata_q[8*k_q +: 8];
        // Read data trails the issuing byte cycle by one clock.
        if (!we_q && k_q != 2'd0) begin
          rdata_d[8*cap_idx +: 8] = tmr_din;
        end
        k_d = k_q + 2'd1;
        if (k_q == LAST_K) begin
          state_d = we_q ? RESP : DRAIN;
        end
      end
      DRAIN: begin
        rdata_d[31:24] = tmr_din;
        state_d        = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_rdata = we_q ? 32'd0 : rdata_q;
        mask_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    irq_d = tmr_irq_in & ~mask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      id_q      <= 1'b0;
      rr_last_q <= 1'b1;
      mask_q    <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      id_q      <= id_d;
      rr_last_q <= rr_last_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_timer_bus_ctrl.sv
// Random and directed stimulus for timer_bus_ctrl against a
// word-level transaction model with a byte-array timer.
module tb_timer_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [33:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_rdata;
  logic        tmr_en;
  logic        tmr_r_nw;
  logic [16:0] tmr_addr;
  logic [7:0]  tmr_dout;
  logic [7:0]  tmr_din = '0;
  logic        tmr_irq_in = 1'b0;
  logic        irq_out;

  timer_bus_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_rdata (resp_rdata),
    .tmr_en     (tmr_en),
    .tmr_r_nw   (tmr_r_nw),
    .tmr_addr   (tmr_addr),
    .tmr_dout   (tmr_dout),
    .tmr_din    (tmr_din),
    .tmr_irq_in (tmr_irq_in),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [31:0] wd;
  } op_t;

  op_t         q0[$];
  op_t         q1[$];
  int          gseq[$];
  logic [7:0]  tmem[0:31];
  logic [31:0] wmem[0:7];

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          idle_at = 0;
  int          vprob = 100;
  int          irq_mode = 0;
  int          irq0 = 0;
  int          m_from = -10;
  int          m_to = -10;
  logic        last_g = 1'b1;
  logic        act = 1'b0;
  logic        a_id, a_we;
  logic [16:0] a_addr;
  logic [31:0] a_wd, a_exp;
  int          a_t = 0;
  logic        exp_irq = 1'b0;
  logic        have_pend = 1'b0;
  logic [7:0]  pend = '0;
  logic [31:0] last_rdata = '0;
  int          last_lat = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic push(input int r, input logic we,
                      input logic [16:0] addr, input logic [31:0] wd);
    op_t op;
    op.we = we;
    op.addr = addr;
    op.wd = wd;
    if (r == 0) q0.push_back(op);
    else q1.push_back(op);
  endtask

  task automatic step();
    logic [1:0]  v, erdy;
    logic        g, mk;
    logic [1:0]  kk;
    logic [26:0] ebus;
    logic [33:0] eresp;
    op_t         op;
    int          lat;
    @(negedge clk);
    v[0] = (q0.size() > 0) && ($urandom_range(0, 99) < vprob);
    v[1] = (q1.size() > 0) && ($urandom_range(0, 99) < vprob);
    req_valid = v;
    req_we = 2'($urandom);
    req_addr = {2'($urandom), $urandom};
    req_wdata = {$urandom, $urandom};
    if (q0.size() > 0) begin
      req_we[0] = q0[0].we;
      req_addr[16:0] = q0[0].addr;
      req_wdata[31:0] = q0[0].wd;
    end
    if (q1.size() > 0) begin
      req_we[1] = q1[0].we;
      req_addr[33:17] = q1[0].addr;
      req_wdata[63:32] = q1[0].wd;
    end
    tmr_din = have_pend ? pend : 8'($urandom);
    have_pend = 1'b0;
    if (irq_mode == 1) tmr_irq_in = 1'b1;
    else tmr_irq_in = ($urandom_range(0, 2) == 0);
    #1;
    erdy = '0;
    g = 1'b0;
    if (cyc >= idle_at && v != 2'b00) begin
      g = (v == 2'b11) ? ~last_g : v[1];
      erdy[g] = 1'b1;
    end
    chk("ready", 64'(req_ready), 64'(erdy));
    ebus = '0;
    if (act && cyc > a_t && cyc <= a_t + 4) begin
      kk = 2'(cyc - a_t - 1);
      ebus = {1'b1, ~a_we, a_addr[16:2], kk, a_wd[8*kk +: 8]};
    end
    chk("tmr_bus", 64'({tmr_en, tmr_r_nw, tmr_addr, tmr_dout}),
        64'(ebus));
    lat = a_we ? 5 : 6;
    eresp = '0;
    if (act && cyc == a_t + lat) eresp = {1'b1, a_id, a_exp};
    chk("resp", 64'({resp_valid, resp_id, resp_rdata}), 64'(eresp));
    chk("irq", 64'(irq_out), 64'(exp_irq));
    if (!irq_out) irq0++;
    if (resp_valid) begin
      last_rdata = resp_rdata;
      last_lat = cyc - a_t;
    end
    if (act && cyc == a_t + lat) act = 1'b0;
    if (tmr_en) begin
      if (tmr_r_nw) begin
        pend = tmem[tmr_addr[4:0]];
        have_pend = 1'b1;
      end else begin
        tmem[tmr_addr[4:0]] = tmr_dout;
      end
    end
    if (erdy != 2'b00) begin
      if (g) op = q1.pop_front();
      else op = q0.pop_front();
      act = 1'b1;
      a_id = g;
      a_we = op.we;
      a_addr = op.addr;
      a_wd = op.wd;
      a_t = cyc;
      a_exp = op.we ? 32'd0 : wmem[op.addr[4:2]];
      if (op.we) wmem[op.addr[4:2]] = op.wd;
      idle_at = cyc + (op.we ? 6 : 7);
      last_g = g;
      gseq.push_back(int'(g));
      if (op.we && op.addr[3:2] == 2'b01) begin
        m_from = cyc;
        m_to = cyc + 4;
      end
    end
    mk = (cyc >= m_from) && (cyc <= m_to);
    exp_irq = tmr_irq_in & ~mk;
    cyc++;
  endtask

  task automatic do_reset(input bit mid);
    @(negedge clk);
    if (mid) chk("pre_rst_en", 64'(tmr_en), 64'd1);
    rst_n = 1'b0;
    req_valid = '0;
    tmr_irq_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("rst_outs", {req_ready, resp_valid, resp_id, resp_rdata, tmr_en,
                       tmr_r_nw, tmr_addr, tmr_dout, irq_out}, 64'd0);
      cyc++;
    end
    rst_n = 1'b1;
    act = 1'b0;
    idle_at = 0;
    last_g = 1'b1;
    exp_irq = 1'b0;
    have_pend = 1'b0;
    m_from = -10;
    m_to = -10;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || act || cyc < idle_at)
           && n < budget) begin
      step();
      n++;
    end
    chk("drained", 64'(q0.size() + q1.size() + int'(act)), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tmem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++)
      wmem[i] = {tmem[4*i+3], tmem[4*i+2], tmem[4*i+1], tmem[4*i]};
    do_reset(1'b0);

    vprob = 100;
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'($urandom), {12'($urandom), 3'($urandom), 2'($urandom)},
           $urandom);
      push(1, 1'($urandom), {12'($urandom), 3'($urandom), 2'($urandom)},
           $urandom);
    end
    run_idle(200);
    chk("alt_count", 64'(gseq.size()), 64'd8);
    for (int i = 0; i < 8 && i < gseq.size(); i++)
      chk("alt_grant", 64'(gseq[i]), 64'(i % 2));

    tmem[4] = 8'h11;
    tmem[5] = 8'h22;
    tmem[6] = 8'h33;
    tmem[7] = 8'h44;
    wmem[1] = 32'h44332211;
    push(0, 1'b0, 17'h00004, $urandom);
    run_idle(50);
    chk("rd_data", 64'(last_rdata), 64'h44332211);
    chk("rd_lat", 64'(last_lat), 64'd6);

    push(1, 1'b1, 17'h00004, 32'hDEADBEEF);
    run_idle(50);
    chk("wr_bytes", 64'({tmem[7], tmem[6], tmem[5], tmem[4]}),
        64'hDEADBEEF);
    chk("wr_lat", 64'(last_lat), 64'd5);

    irq_mode = 1;
    repeat (3) step();
    irq0 = 0;
    push(0, 1'b1, 17'h00005, $urandom);
    run_idle(50);
    chk("cmp_mask_cycles", 64'(irq0), 64'd5);
    repeat (2) step();
    irq0 = 0;
    push(1, 1'b1, 17'h00002, $urandom);
    run_idle(50);
    repeat (2) step();
    chk("mtime_no_mask", 64'(irq0), 64'd0);
    irq_mode = 0;

    push(0, 1'b0, 17'h00008, $urandom);
    for (int n = 0; n < 50 && !(act && cyc == a_t + 3); n++) step();
    chk("mid_reached", 64'(act && cyc == a_t + 3), 64'd1);
    do_reset(1'b1);
    push(0, 1'b0, 17'h00008, $urandom);
    run_idle(50);
    chk("post_rst_rd", 64'(last_rdata),
        64'({tmem[11], tmem[10], tmem[9], tmem[8]}));
    chk("post_rst_lat", 64'(last_lat), 64'd6);

    vprob = 70;
    for (int i = 0; i < 80; i++)
      push($urandom_range(0, 1), 1'($urandom),
           {12'($urandom), 3'($urandom), 2'($urandom)}, $urandom);
    run_idle(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/timer_bus_ctrl.md
Name: timer_bus_ctrl

Overview:
- Sequencer and arbiter in front of the byte-wide memory-mapped timer.
- Accepts 32-bit word read/write requests from two requesters (0 = LSU, 1 = debug/IO bridge) and arbitrates round-robin between them.
- Splits each request into four little-endian byte cycles on the 8-bit timer bus and reassembles read data.
- Masks the timer interrupt while a compare register is only partially written.

Parameters:
- ADDR_WIDTH, 17, byte address width of the timer bus.
- CMP_SEL, 2'b01, value of addr[3:2] that selects the compare register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot pulse
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  word addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  64  write data; requester i uses slice [i*32 +: 32]
- resp_valid  out  1  one-cycle response pulse
- resp_id  out  1  requester index for the response
- resp_rdata  out  32  read word; 0 for writes
- tmr_en  out  1  byte-cycle enable to the timer
- tmr_r_nw  out  1  1 = read, 0 = write
- tmr_addr  out  ADDR_WIDTH  byte address
- tmr_dout  out  8  write byte
- tmr_din  in  8  read byte, valid the cycle after the issuing tmr_en
- tmr_irq_in  in  1  raw timer interrupt
- irq_out  out  1  registered, masked interrupt

Behaviour:
- Reset: clk and rst_n only. Reset is asynchronous and active-low.
  - State IDLE. All outputs 0.
  - rr_last = 1, so requester 0 wins the first tie.
  - mask = 0. Read buffer cleared.
  - Asserting reset mid-operation abandons the transaction: tmr_en drops immediately and no response is emitted.
- Arbitration, in IDLE only:
  - If exactly one req_valid is high, grant it.
  - If both are high, grant the index != rr_last.
  - req_ready[g] = 1 combinationally in IDLE for the granted index.
  - On accept: latch we, addr[ADDR_WIDTH-1:2], wdata and id; set rr_last = g; go to ISSUE with byte counter k = 0.
- ISSUE (4 cycles, k = 0..3):
  - tmr_en = 1, tmr_r_nw = ~we, tmr_addr = {addr_hi, k[1:0]}.
  - tmr_dout = wdata[8k+7:8k].
  - After k = 3: write goes to RESP; read goes to DRAIN.
- Read capture: registered 1-cycle pipeline.
  - tmr_din captured into rdata[8k+7:8k] for the byte issued the previous cycle.
  - Bytes 0..2 are captured during ISSUE cycles 1..3; byte 3 is captured in DRAIN.
- DRAIN: 1 cycle, tmr_en = 0, captures byte 3, then goes to RESP.
- RESP: 1 cycle.
  - resp_valid = 1, resp_id = latched id.
  - resp_rdata = rdata for reads, 0 for writes.
  - Next state IDLE; the earliest next accept is the following cycle.
- Latency:
  - Write: accept at cycle T; bytes at T+1..T+4; resp at T+5.
  - Read: bytes at T+1..T+4; resp at T+6.
- Addresses: addr[1:0] of the request is ignored, so there are no unaligned accesses.
- Interrupt mask:
  - Set at accept of a write whose addr[3:2] == CMP_SEL.
  - Cleared in RESP.
  - irq_out <= tmr_irq_in & ~mask, registered, giving 1-cycle latency.
  - Reads and non-compare writes never set the mask.
- Simultaneous events:
  - A req_valid arriving during a busy period waits; it is not dropped.
  - A requester may drop valid before accept with no effect.
  - Requests are held while busy.

Decomposition:
- Shared package timer_pkg:
  - state enum {IDLE, ISSUE, DRAIN, RESP}
  - CMP_SEL and the timer register offsets (mtime = 2'b00, cmp = 2'b01)
  - BYTES_PER_WORD = 4
- One natural sub-module: rr_arb2, the 2-way round-robin arbiter (valid[1:0], rr_last -> grant one-hot).
- The byte sequencer and capture logic stay in the top level.

Test Plan:
- Read, req0 only, addr 0x00004, tmr_din returns 0x11,0x22,0x33,0x44 in order:
  - tmr_addr sequence is 0x4,0x5,0x6,0x7.
  - resp_valid at T+6 with resp_rdata = 0x44332211, resp_id = 0.
- Write, req1, addr 0x00004, wdata 0xDEADBEEF:
  - tmr_dout sequence is EF,BE,AD,DE with tmr_r_nw = 0.
  - resp at T+5 with resp_rdata = 0.
- Both valid after reset, then both again:
  - First grant is 0, then 1; no starvation across 4 back-to-back pairs (alternation 0,1,0,1).
- tmr_irq_in held 1 during a compare write:
  - irq_out = 0 from T+1 through the RESP cycle.
  - irq_out returns to 1 the cycle after RESP.
- Write to addr 0x00000 (mtime) with tmr_irq_in = 1:
  - irq_out stays 1 throughout.
- rst_n pulled low at k = 2 of a read:
  - tmr_en = 0 immediately, no resp_valid.
  - After release, a fresh req0 read completes normally with correct data.
